// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with modulus, wrap/saturate mode, parallel load,
// a registered terminal-count pulse and a sticky overflow flag.
module up_down_counter_param #(
  parameter int unsigned       WIDTH    = 4,
  parameter longint unsigned   MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit                SATURATE = 1'b0,
  parameter longint unsigned   RST_VAL  = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             zero,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;

  assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
  assign zero         = (q == '0);
  assign at_max       = (q == MAX_Q);

  // Boundary handling uses the decodes so wrap happens at MAX_VAL, not at binary rollover.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = load_clamped;
    end else if (en) begin
      if (up_down) begin
        if (at_max) begin
          tc_next = 1'b1;
          q_next  = SATURATE ? q : '0;
        end else begin
          q_next = q + 1'b1;
        end
      end else begin
        if (zero) begin
          tc_next = 1'b1;
          q_next  = SATURATE ? q : MAX_Q;
        end else begin
          q_next = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= RST_Q;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      tc  <= tc_next;
      ovf <= tc_next | (ovf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_up_down_counter_param.sv
// Bench for up_down_counter_param: three instances (mod-16 wrap, decade wrap,
// mod-13 saturate) share stimulus; expected outputs are queued and compared after each edge.
module tb_up_down_counter_param;

  localparam int N = 3;
  localparam int MAXS [N] = '{15, 9, 12};
  localparam bit SATS [N] = '{1'b0, 1'b0, 1'b1};

  typedef struct {
    int   q;
    logic tc;
    logic ovf;
    logic zero;
    logic at_max;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       clr_flags = 1'b0;

  logic [3:0] q_o      [N];
  logic       tc_o     [N];
  logic       ovf_o    [N];
  logic       zero_o   [N];
  logic       at_max_o [N];

  exp_t sb[$];
  int   m_q [N];
  logic m_tc [N];
  logic m_ovf [N];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0), .RST_VAL(0)) u_wrap16 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]),
    .at_max(at_max_o[0]));

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RST_VAL(0)) u_dec (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]),
    .at_max(at_max_o[1]));

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(12), .SATURATE(1'b1), .RST_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]),
    .at_max(at_max_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one counter for the inputs about to be sampled.
  task automatic model_edge(input int i);
    int  mx;
    bit  boundary;
    mx = MAXS[i];
    boundary = 1'b0;
    if (!rst) begin
      m_q[i] = 0;
      m_tc[i] = 1'b0;
      m_ovf[i] = 1'b0;
      return;
    end
    if (load) begin
      m_q[i] = (int'(load_val) > mx) ? mx : int'(load_val);
    end else if (en && up_down) begin
      if (m_q[i] == mx) begin
        boundary = 1'b1;
        if (!SATS[i]) m_q[i] = 0;
      end else m_q[i] = m_q[i] + 1;
    end else if (en) begin
      if (m_q[i] == 0) begin
        boundary = 1'b1;
        if (!SATS[i]) m_q[i] = mx;
      end else m_q[i] = m_q[i] - 1;
    end
    m_tc[i] = boundary;
    if (boundary) m_ovf[i] = 1'b1;
    else if (clr_flags) m_ovf[i] = 1'b0;
  endtask

  task automatic step(input logic r, input logic e, input logic ud, input logic ld,
                      input logic [3:0] lv, input logic cf);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up_down = ud; load = ld; load_val = lv; clr_flags = cf;
    for (int i = 0; i < N; i++) begin
      model_edge(i);
      x.q = m_q[i];
      x.tc = m_tc[i];
      x.ovf = m_ovf[i];
      x.zero = (m_q[i] == 0);
      x.at_max = (m_q[i] == MAXS[i]);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    chk("sb_depth", sb.size(), N);
    for (int i = 0; i < N; i++) begin
      if (sb.size() == 0) break;
      x = sb.pop_front();
      chk($sformatf("q[%0d]", i), 32'(q_o[i]), 32'(x.q));
      chk($sformatf("tc[%0d]", i), 32'(tc_o[i]), 32'(x.tc));
      chk($sformatf("ovf[%0d]", i), 32'(ovf_o[i]), 32'(x.ovf));
      chk($sformatf("zero[%0d]", i), 32'(zero_o[i]), 32'(x.zero));
      chk($sformatf("at_max[%0d]", i), 32'(at_max_o[i]), 32'(x.at_max));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_q[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
    end

    // Reset with load/en active: they must be ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("rst_q", 32'(q_o[0]), 32'd0);
    chk("rst_zero", 32'(zero_o[0]), 32'd1);

    // Free count through the mod-16 wrap.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("wrap16_q", 32'(q_o[0]), 32'd0);
    chk("wrap16_tc", 32'(tc_o[0]), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("wrap16_ovf", 32'(ovf_o[0]), 32'd1);
    chk("wrap16_tc_drop", 32'(tc_o[0]), 32'd0);

    // Decade down-count from 2.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("dec_q", 32'(q_o[1]), 32'd8);

    // Saturate up from 10, then down at 0.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("sat_q", 32'(q_o[2]), 32'd12);
    chk("sat_tc", 32'(tc_o[2]), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("sat_low_q", 32'(q_o[2]), 32'd0);

    // Load beats count and clamps above MAX_VAL.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0);
    chk("clamp_q", 32'(q_o[1]), 32'd9);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

    // Mid-count reset, then direction flip.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("midrst_ovf", 32'(ovf_o[1]), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("flip_q", 32'(q_o[0]), 32'd0);

    // Sticky flag: set wins over clear, then a lone clear drops it.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("sticky_set", 32'(ovf_o[0]), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("sticky_clr", 32'(ovf_o[0]), 32'd0);

    // Random mix.
    for (int k = 0; k < 120; k++)
      step(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), logic'($urandom_range(0, 5) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
